// File: rtl/clk_div_pkg.sv
// Shared types for the clk_div_n divider (tick output gated by CLK_DIV_TICK_EN).
// No logic here; latency and backpressure are not applicable.
package clk_div_pkg;
  localparam int CNT_W_DFLT = 8;
  localparam int DIV_MIN    = 2;

  typedef logic [CNT_W_DFLT-1:0] div_t;
  typedef enum logic {RUN, IDLE} run_state_t;
endpackage

// File: rtl/clk_div_phase.sv
// Negedge retimer and odd/even output select for clk_div_n; half-cycle latency on q_n.
// No backpressure; all inputs come from flops so out_clk has no path from module inputs.
module clk_div_phase
  import clk_div_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic q_p,
  input  logic odd,
  output logic out_clk
);
  logic q_n;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) q_n <= 1'b0;
    else      q_n <= q_p;
  end

  // q_p and q_n change on opposite edges, so the AND cannot glitch.
  assign out_clk = odd ? (q_p & q_n) : q_p;
endmodule

// File: rtl/clk_div_n.sv
// Divide-by-N clock, 50% duty for odd N; out_clk starts one posedge after en, optional tick via CLK_DIV_TICK_EN.
// Divisor loads use a busy/ack handshake and take effect only at a period boundary.
module clk_div_n
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DIV_DEFAULT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             div_busy,
  output logic             div_ack,
  output logic             div_err,
  output logic             out_clk
`ifdef CLK_DIV_TICK_EN
  , output logic           tick
`endif
);
  run_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] n;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] pend_val;
  logic             pend_vld;
  logic             q_p;
  logic             boundary;
  logic             apply;
  logic             load_ok;

  // For odd N the high phase is rounded up here and trimmed by half a cycle in clk_div_phase.
  assign half     = (n >> 1) + CNT_W'(n[0]);
  assign cnt_inc  = cnt + 1'b1;
  assign boundary = (state == RUN) && (cnt == n - 1'b1);
  assign apply    = pend_vld && (boundary || state == IDLE);
  assign load_ok  = div_load && (div_in >= CNT_W'(DIV_MIN));
  assign div_busy = pend_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      n        <= CNT_W'(DIV_DEFAULT);
      pend_val <= '0;
      pend_vld <= 1'b0;
      q_p      <= 1'b0;
      div_ack  <= 1'b0;
      div_err  <= 1'b0;
`ifdef CLK_DIV_TICK_EN
      tick     <= 1'b0;
`endif
    end else begin
      div_ack <= apply;
      div_err <= div_load && !load_ok;
      if (apply) n <= pend_val;
      // A load coinciding with an apply becomes the next pending value.
      if (load_ok) begin
        pend_vld <= 1'b1;
        pend_val <= div_in;
      end else if (apply) begin
        pend_vld <= 1'b0;
      end
`ifdef CLK_DIV_TICK_EN
      tick <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt <= '0;
          if (en) begin
            state <= RUN;
            q_p   <= 1'b1;
`ifdef CLK_DIV_TICK_EN
            tick  <= 1'b1;
`endif
          end else begin
            q_p <= 1'b0;
          end
        end
        RUN: begin
          if (boundary) begin
            cnt <= '0;
            if (en) begin
              q_p  <= 1'b1;
`ifdef CLK_DIV_TICK_EN
              tick <= 1'b1;
`endif
            end else begin
              state <= IDLE;
              q_p   <= 1'b0;
            end
          end else begin
            cnt <= cnt_inc;
            q_p <= (cnt_inc < half);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  clk_div_phase u_phase (
    .clk     (clk),
    .rst     (rst),
    .q_p     (q_p),
    .odd     (n[0]),
    .out_clk (out_clk)
  );
endmodule
